pdm_capture_writer: RTL
=======================

PDM_CAPTURE_WRITER -- requirements
Module: pdm_capture_writer

Interface
REQ-001 Parameter CLK_DIV, default 25: system-clock cycles per mic_clk half-period (100 MHz -> 2 MHz mic clock).
REQ-002 Parameter DEPTH, default 32768: words per memory block; the bench overrides it.
REQ-003 Port clock, in, 1: system clock, the only clock; all logic on its rising edge.
REQ-004 Port reset, in, 1: synchronous, active-high reset.
REQ-005 Port record, in, 1: a rising edge starts a capture.
REQ-006 Port microphone, in, 1: PDM data bit from the microphone.
REQ-007 Port mic_clk, out, 1: divided clock driven to the microphone.
REQ-008 Port data, out, 16: assembled sample word for memory.
REQ-009 Port memaddr, out, 16: write address within the selected block.
REQ-010 Ports block1ena/block1wea, out, 1 each: enable and write-enable for memory block 1.
REQ-011 Ports block2ena/block2wea, out, 1 each: enable and write-enable for memory block 2.
REQ-012 Port recording, out, 1: high while a capture is in progress.
REQ-013 Port done, out, 1: high while in DONE (both blocks full).

Function
REQ-014 mic_clk SHALL toggle every CLK_DIV cycles while recording=1 and SHALL be held at 0 otherwise.
REQ-015 A one-cycle sample strobe SHALL fire on the cycle mic_clk goes 0->1; microphone SHALL be sampled only on that strobe.
REQ-016 Sampled bits SHALL be shifted MSB-first into a 16-bit register; the first sampled bit lands in data[15].
REQ-017 State machine states: IDLE, SHIFT, WRITE, DONE.
REQ-018 IDLE->SHIFT on a record rising edge (record=1 now, 0 on the previous cycle). Bit count, memaddr and block select SHALL clear on this transition.
REQ-019 SHIFT->WRITE on the cycle after the 16th strobe of the current word.
REQ-020 In WRITE, for exactly one cycle: blockNena=blockNwea=1 for the selected block only, with data and memaddr stable.
REQ-021 WRITE->SHIFT on the next cycle. memaddr SHALL increment then. When memaddr was DEPTH-1 in block 1, memaddr SHALL wrap to 0 and block 2 becomes selected.
REQ-022 WRITE->DONE after writing address DEPTH-1 of block 2. mic_clk SHALL stop and done=1.
REQ-023 DONE->SHIFT on a new record rising edge; restarts at block 1, address 0.
REQ-024 Record edges while in SHIFT or WRITE SHALL be ignored; record level has no effect after the start edge.
REQ-025 All ena/wea outputs SHALL be 0 outside WRITE.
REQ-026 recording SHALL be 1 in SHIFT and WRITE only.
REQ-027 data SHALL hold the last written word until the next WRITE.
REQ-028 Total capture per start SHALL be exactly 2*DEPTH words, i.e. 32*DEPTH strobes.

Reset
REQ-029 Reset SHALL return the FSM to IDLE, including mid-capture. Every output SHALL be 0 (mic_clk, data, memaddr, all ena/wea, recording, done). Divider, bit counter and record edge register SHALL clear.
REQ-030 A record rising edge coincident with reset SHALL be ignored. Reset has priority over every transition.

Structure
REQ-031 Package audio_pkg SHALL hold the WORD_W=16 constant, the default CLK_DIV, and the capture state enum typedef, for sharing with the playback serializer.
REQ-032 Sub-module mic_clk_gen SHALL contain the divider and emit mic_clk and the sample strobe, with an enable input.

Verification (CLK_DIV=2, DEPTH=4)
REQ-033 Reset, then a record pulse; microphone held 1 -> first WRITE: block1ena=block1wea=1, memaddr=0, data=16'hFFFF, for one cycle.
REQ-034 Microphone drives the pattern 1010... per strobe -> every written word is 16'hAAAA; memaddr sequence is 0,1,2,3 on block 1, then 0,1,2,3 on block 2; done=1 after the 8th write; exactly 128 strobes.
REQ-035 Extra record pulse during SHIFT -> no restart; write count and address sequence unchanged.
REQ-036 Reset asserted during the 3rd word -> next cycle all outputs 0, state IDLE. A new record edge then restarts at block 1, memaddr=0.
REQ-037 From DONE, record rising edge -> recording=1, done=0, mic_clk resumes; first write goes to block 1, address 0.
REQ-038 Record held high continuously from reset release -> exactly one capture; no re-trigger from DONE without a falling then rising edge.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio definitions for the PDM capture writer and the playback serializer.
package audio_pkg;

    // Width of one assembled PCM/PDM word.
    localparam int WORD_W = 16;

    // System-clock cycles per mic_clk half-period (100 MHz -> 2 MHz mic clock).
    localparam int CLK_DIV_DEFAULT = 25;

    // Width of the per-word bit counter.
    localparam int BITCNT_W = $clog2(WORD_W);

    // Capture sequencer states.
    typedef enum logic [1:0] {
        CAP_IDLE  = 2'd0,
        CAP_SHIFT = 2'd1,
        CAP_WRITE = 2'd2,
        CAP_DONE  = 2'd3
    } cap_state_e;

    // Shift one bit into the LSB so the first bit ends up in the MSB.
    function automatic logic [WORD_W-1:0] shift_in_msb(input logic [WORD_W-1:0] word,
                                                        input logic            bit_i);
        return {word[WORD_W-2:0], bit_i};
    endfunction

endpackage

// File: rtl/mic_clk_gen.sv
// Microphone clock divider: toggles mic_clk every CLK_DIV cycles while enabled
// and emits a one-cycle strobe on the cycle mic_clk becomes 1.
module mic_clk_gen
    import audio_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic mic_clk,
    output logic strobe
);

    localparam int                CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             mic_clk_q;
    logic             mic_clk_d;
    logic             strobe_q;
    logic             strobe_d;

    // Next divider count, clock level and strobe; disabled divider parks at 0.
    always_comb begin
        cnt_d     = cnt_q;
        mic_clk_d = mic_clk_q;
        strobe_d  = 1'b0;
        if (!enable) begin
            cnt_d     = '0;
            mic_clk_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d     = '0;
            mic_clk_d = ~mic_clk_q;
            strobe_d  = ~mic_clk_q;
        end else begin
            cnt_d     = cnt_q + CNT_W'(1);
        end
    end

    // Divider state registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q     <= '0;
            mic_clk_q <= 1'b0;
            strobe_q  <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            mic_clk_q <= mic_clk_d;
            strobe_q  <= strobe_d;
        end
    end

    assign mic_clk = mic_clk_q;
    assign strobe  = strobe_q;

endmodule

// File: rtl/pdm_capture_writer.sv
// PDM microphone capture: assembles 16-bit words from the mic bitstream and
// writes them into two memory blocks of DEPTH words each, then stops.
module pdm_capture_writer
    import audio_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT,
    parameter int DEPTH   = 32768
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              record,
    input  logic              microphone,
    output logic              mic_clk,
    output logic [WORD_W-1:0] data,
    output logic [15:0]       memaddr,
    output logic              block1ena,
    output logic              block1wea,
    output logic              block2ena,
    output logic              block2wea,
    output logic              recording,
    output logic              done
);

    localparam logic [15:0]         LAST_ADDR = 16'(DEPTH - 1);
    localparam logic [BITCNT_W-1:0] BIT_LAST  = BITCNT_W'(WORD_W - 1);

    cap_state_e          state_q;
    cap_state_e          state_d;
    logic [BITCNT_W-1:0] bitcnt_q;
    logic [BITCNT_W-1:0] bitcnt_d;
    logic [WORD_W-1:0]   shift_q;
    logic [WORD_W-1:0]   shift_d;
    logic [WORD_W-1:0]   data_q;
    logic [WORD_W-1:0]   data_d;
    logic [15:0]         addr_q;
    logic [15:0]         addr_d;
    logic                sel_q;      // 0: block 1, 1: block 2
    logic                sel_d;
    logic                rec_prev_q;
    logic                rec_out_q;
    logic                rec_out_d;
    logic                done_q;
    logic                done_d;
    logic                blk1_we_q;
    logic                blk1_we_d;
    logic                blk2_we_q;
    logic                blk2_we_d;
    logic                rec_edge;
    logic                strobe;

    assign rec_edge = record & ~rec_prev_q;

    // The divider follows the next recording level so mic_clk stops on the
    // same edge the sequencer enters DONE or IDLE.
    mic_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_mic_clk_gen (
        .clock   (clock),
        .reset   (reset),
        .enable  (rec_out_d),
        .mic_clk (mic_clk),
        .strobe  (strobe)
    );

    // Sequencer next-state logic and next values of the registered outputs.
    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        data_d   = data_q;
        addr_d   = addr_q;
        sel_d    = sel_q;
        case (state_q)
            CAP_IDLE, CAP_DONE: begin
                if (rec_edge) begin
                    state_d  = CAP_SHIFT;
                    bitcnt_d = '0;
                    shift_d  = '0;
                    addr_d   = 16'd0;
                    sel_d    = 1'b0;
                end else begin
                    state_d  = state_q;
                end
            end
            CAP_SHIFT: begin
                if (strobe) begin
                    shift_d = shift_in_msb(shift_q, microphone);
                    if (bitcnt_q == BIT_LAST) begin
                        bitcnt_d = '0;
                        data_d   = shift_in_msb(shift_q, microphone);
                        state_d  = CAP_WRITE;
                    end else begin
                        bitcnt_d = bitcnt_q + BITCNT_W'(1);
                    end
                end else begin
                    shift_d = shift_q;
                end
            end
            CAP_WRITE: begin
                if (addr_q == LAST_ADDR) begin
                    if (sel_q) begin
                        state_d = CAP_DONE;
                    end else begin
                        state_d = CAP_SHIFT;
                        addr_d  = 16'd0;
                        sel_d   = 1'b1;
                    end
                end else begin
                    state_d = CAP_SHIFT;
                    addr_d  = addr_q + 16'd1;
                end
            end
            default: begin
                state_d = CAP_IDLE;
            end
        endcase

        rec_out_d = (state_d == CAP_SHIFT) || (state_d == CAP_WRITE);
        done_d    = (state_d == CAP_DONE);
        blk1_we_d = (state_d == CAP_WRITE) && !sel_d;
        blk2_we_d = (state_d == CAP_WRITE) &&  sel_d;
    end

    // Sequencer and output registers; reset wins over every transition.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= CAP_IDLE;
            bitcnt_q   <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            addr_q     <= 16'd0;
            sel_q      <= 1'b0;
            rec_prev_q <= 1'b0;
            rec_out_q  <= 1'b0;
            done_q     <= 1'b0;
            blk1_we_q  <= 1'b0;
            blk2_we_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            addr_q     <= addr_d;
            sel_q      <= sel_d;
            rec_prev_q <= record;
            rec_out_q  <= rec_out_d;
            done_q     <= done_d;
            blk1_we_q  <= blk1_we_d;
            blk2_we_q  <= blk2_we_d;
        end
    end

    assign data      = data_q;
    assign memaddr   = addr_q;
    assign block1ena = blk1_we_q;
    assign block1wea = blk1_we_q;
    assign block2ena = blk2_we_q;
    assign block2wea = blk2_we_q;
    assign recording = rec_out_q;
    assign done      = done_q;

endmodule
